axilite_cmd_master: RTL and testbench
=====================================

# axilite_cmd_master

AXI-Lite initiator that turns single-beat commands from a simple valid/ready command port into AXI-Lite write or read transactions. It drives the FIR block's AXI-Lite configuration responder, which holds ap_control at 0x000, data_length at 0x010 and taps at 0x020–0x0FF. It is the host-side end of that interface and sits between the user-project bus bridge and the FIR configuration port. Each command completes with one response: read data, or an error on timeout.

## Interface
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, AXI-Lite data width
- pTIMEOUT, 256, maximum cycles a transaction may wait for its handshakes; 0 disables the timeout

Ports:
- axis_clk  in  1  single clock
- axis_rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  pADDR_WIDTH  byte address
- cmd_wdata  in  pDATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_err  out  1  transaction timed out
- rsp_rdata  out  pDATA_WIDTH  read data; 0 for writes and for errors
- awvalid, awready, awaddr (out/in/out, 1/1/pADDR_WIDTH)  write-address channel
- wvalid, wready, wdata (out/in/out, 1/1/pDATA_WIDTH)  write-data channel
- arvalid, arready, araddr (out/in/out, 1/1/pADDR_WIDTH)  read-address channel
- rvalid, rready, rdata (in/out/in, 1/1/pDATA_WIDTH)  read-data channel

The interface has no B channel. A write is complete once both the AW and W handshakes have occurred.

## Operation
- States are IDLE, WR, RD_A, RD_D and RSP. All outputs are registered.
- IDLE:
  - cmd_ready is 1.
  - On cmd_valid, latch cmd_addr and cmd_wdata, clear the timeout counter, and go to WR if cmd_we=1, otherwise RD_A.
- WR:
  - awvalid and wvalid are both asserted on the first WR cycle, with awaddr and wdata driven from the latches.
  - Each valid drops on the cycle after its own handshake and stays low afterwards. Because the responder needs both valids present, simultaneous handshakes are the normal case.
  - When both handshakes are done, go to RSP with rsp_err=0 and rsp_rdata=0.
- RD_A:
  - arvalid=1, araddr comes from the latch, and rready=1.
  - The responder gates arready with rready and returns rvalid combinationally. On arvalid&arready:
    - if rvalid is also high in that cycle, capture rdata into rsp_rdata and go to RSP;
    - otherwise drop arvalid and go to RD_D.
  - rvalid without arready in RD_A is ignored.
- RD_D: rready=1. On rvalid, capture rdata and go to RSP.
- RSP:
  - rsp_valid=1 and all AXI valids and rready are 0.
  - Hold rsp_err and rsp_rdata stable until rsp_ready, then go to IDLE.
- Timeout (pTIMEOUT≠0):
  - The counter increments every cycle in WR, RD_A and RD_D.
  - If the pending transaction has not completed when count = pTIMEOUT-1, deassert all AXI valids and rready next cycle and go to RSP with rsp_err=1 and rsp_rdata=0.
  - A handshake that completes in that same cycle wins over the timeout.
- Addresses and data pass through unmodified. The block does no range checking.

## Timing
- Reset values:
  - cmd_ready=0 during reset, then 1 in IDLE on the first cycle after deassertion.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - awvalid=wvalid=arvalid=rready=0.
  - awaddr=araddr=wdata=0.
  - The state machine resets to IDLE.
- Reset asserted mid-transaction returns the block to IDLE immediately. All valids drop asynchronously and no response is produced.
- Command accepted at cycle 0:
  - the first AXI valid appears at cycle 1;
  - if handshakes complete at cycle N, rsp_valid rises at N+1.
- Best-case latency from command accept to rsp_valid is 2 cycles for a write and 2 cycles for a read, since the responder answers AR and R in the same cycle.
- The throughput limit is one command in flight. With rsp_ready held high, cmd_ready returns the cycle after rsp_valid.
- An AXI valid, once asserted, is never withdrawn before its handshake, except on timeout or reset.
- rready is asserted only in RD_A and RD_D.

## Test plan
- Write 0x010 ← 0x00000258 with a responder ready immediately: awvalid and wvalid are high for exactly one cycle; rsp_valid comes 2 cycles after accept with rsp_err=0; the responder's data_length reads 600.
- Write tap 0x024 ← 0xFFFFFFFE, then read 0x024: the read returns rsp_rdata=0xFFFFFFFE 2 cycles after accept.
- Skewed write: wready is delayed 3 cycles after awready. awvalid drops after its handshake, wvalid is held, and rsp_valid rises one cycle after the W handshake.
- Split read: arready at cycle 1 and rvalid at cycle 4 with rdata=0x4. The block passes through RD_D, and rsp_rdata=0x00000004 with rsp_valid at cycle 5.
- Timeout with pTIMEOUT=8 and arready held 0: arvalid drops after 8 cycles, then rsp_err=1 and rsp_rdata=0. A following command is accepted normally.
- Backpressure and reset: holding rsp_ready=0 for 5 cycles keeps the response stable and cmd_ready=0. Asserting axis_rst_n=0 mid-WR clears all outputs and leaves no response after release.

Source files
------------

// File: rtl/axilite_cmd_master_if.sv
// Command/response port plus AXI-Lite AW/W/AR/R channels between the host-side
// command master and the FIR configuration responder.
interface axilite_cmd_master_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_we;
  logic [pADDR_WIDTH-1:0] cmd_addr;
  logic [pDATA_WIDTH-1:0] cmd_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_err;
  logic [pDATA_WIDTH-1:0] rsp_rdata;
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  awready, wready, arready, rvalid, rdata,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output awready, wready, arready, rvalid, rdata,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready
  );
endinterface

// File: rtl/axilite_cmd_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AXI-Lite write or read
// out, one response back (read data, or an error when the handshakes time out).
module axilite_cmd_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 256
) (
  input  logic axis_clk,
  input  logic axis_rst_n,
  axilite_cmd_master_if.master bus
);

  localparam int CNT_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (pTIMEOUT > 0) ? CNT_W'(pTIMEOUT - 1) : '0;
  localparam logic TMO_EN = (pTIMEOUT != 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD_A = 3'd2,
    RD_D = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_cmd_ready, w_cmd_ready_nxt;
  logic                   r_awvalid, w_awvalid_nxt;
  logic                   r_wvalid, w_wvalid_nxt;
  logic                   r_arvalid, w_arvalid_nxt;
  logic                   r_rready, w_rready_nxt;
  logic [pADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
  logic [pADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
  logic [pDATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic                   r_rsp_err, w_rsp_err_nxt;
  logic [pDATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [CNT_W-1:0]       r_tmo_cnt, w_tmo_cnt_nxt;

  logic w_accept;
  logic w_wr_done;
  logic w_tmo;

  assign w_accept  = bus.cmd_valid & r_cmd_ready;
  // A valid already low while in WR means that channel's handshake is behind us.
  assign w_wr_done = (~r_awvalid | bus.awready) & (~r_wvalid | bus.wready);
  assign w_tmo     = TMO_EN & (r_tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_awaddr_nxt    = r_awaddr;
    w_araddr_nxt    = r_araddr;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_tmo_cnt_nxt   = r_tmo_cnt + CNT_W'(1);
    case (r_state)
      IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        w_tmo_cnt_nxt   = '0;
        if (w_accept) begin
          w_cmd_ready_nxt = 1'b0;
          w_awaddr_nxt    = bus.cmd_addr;
          w_araddr_nxt    = bus.cmd_addr;
          w_wdata_nxt     = bus.cmd_wdata;
          if (bus.cmd_we) begin
            w_state_nxt   = WR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = RD_A;
            w_arvalid_nxt = 1'b1;
            w_rready_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WR: begin
        if (w_wr_done || w_tmo) begin
          w_state_nxt     = RSP;
          w_awvalid_nxt   = 1'b0;
          w_wvalid_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = ~w_wr_done;
          w_rsp_rdata_nxt = '0;
        end else begin
          w_awvalid_nxt = r_awvalid & ~bus.awready;
          w_wvalid_nxt  = r_wvalid & ~bus.wready;
        end
      end
      RD_A: begin
        // The responder answers R in the AR cycle when it can; otherwise wait in RD_D.
        if (bus.arready && bus.rvalid) begin
          w_state_nxt     = RSP;
          w_arvalid_nxt   = 1'b0;
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = bus.rdata;
        end else if (bus.arready) begin
          w_state_nxt   = RD_D;
          w_arvalid_nxt = 1'b0;
        end else if (w_tmo) begin
          w_state_nxt     = RSP;
          w_arvalid_nxt   = 1'b0;
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
        end else begin
          w_state_nxt = RD_A;
        end
      end
      RD_D: begin
        if (bus.rvalid || w_tmo) begin
          w_state_nxt     = RSP;
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = ~bus.rvalid;
          w_rsp_rdata_nxt = bus.rvalid ? bus.rdata : '0;
        end else begin
          w_state_nxt = RD_D;
        end
      end
      RSP: begin
        w_tmo_cnt_nxt = '0;
        if (bus.rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = RSP;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_cmd_ready_nxt = 1'b0;
        w_awvalid_nxt   = 1'b0;
        w_wvalid_nxt    = 1'b0;
        w_arvalid_nxt   = 1'b0;
        w_rready_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_tmo_cnt_nxt   = '0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_araddr    <= w_araddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.awvalid   = r_awvalid;
  assign bus.awaddr    = r_awaddr;
  assign bus.wvalid    = r_wvalid;
  assign bus.wdata     = r_wdata;
  assign bus.arvalid   = r_arvalid;
  assign bus.araddr    = r_araddr;
  assign bus.rready    = r_rready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_axilite_cmd_master.sv
// Scoreboard bench: a latency-programmable AXI-Lite responder with a register file,
// and a monitor that checks every response against the queued expectation.
module tb_axilite_cmd_master;

  localparam int TMO = 8;

  logic axis_clk = 1'b0;
  logic axis_rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
  bit ar_never = 1'b0;

  logic [31:0] resp_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          aw_hi;
    int          w_hi;
    int          ar_hi;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  axilite_cmd_master_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  axilite_cmd_master #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pTIMEOUT(TMO)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .bus        (bus)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Issue one command and queue the response the reference model predicts.
  task automatic do_cmd(input logic we, input logic [11:0] addr, input logic [31:0] wd, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge axis_clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    chk("cmd_accept", bus.cmd_ready, 1'b1);
    e.acc = cyc;
    if (we) begin
      e.err   = 1'b0;
      e.rdata = 32'h0;
      e.lat   = 2 + ((aw_lat > w_lat) ? aw_lat : w_lat);
      e.aw_hi = aw_lat + 1;
      e.w_hi  = w_lat + 1;
      e.ar_hi = 0;
      if (push) ref_mem[addr[11:2]] = wd;
    end else if (ar_never || ar_lat >= TMO) begin
      e.err   = 1'b1;
      e.rdata = 32'h0;
      e.lat   = TMO + 1;
      e.aw_hi = 0;
      e.w_hi  = 0;
      e.ar_hi = TMO;
    end else begin
      e.err   = 1'b0;
      e.rdata = ref_mem[addr[11:2]];
      e.lat   = 2 + ar_lat + r_lat;
      e.aw_hi = 0;
      e.w_hi  = 0;
      e.ar_hi = ar_lat + 1;
    end
    if (push) exp_q.push_back(e);
    @(posedge axis_clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge axis_clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Responder: programmable ready latencies, R either same-cycle as AR or delayed.
  initial begin
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_wait = 0;
    bit got_aw = 1'b0, got_w = 1'b0;
    logic [9:0]  wr_idx = '0, ar_idx = '0;
    logic [31:0] wr_dat = '0;
    for (int i = 0; i < 1024; i++) resp_mem[i] = 32'h0;
    resp_mem[12] = 32'h4;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.rvalid  = 1'b0; bus.rdata  = 32'h0;
    forever begin
      @(negedge axis_clk);
      if (!axis_rst_n) begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.rvalid  = 1'b0; bus.rdata  = 32'h0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_wait = 0;
        got_aw = 1'b0; got_w = 1'b0;
      end else begin
        bus.awready = bus.awvalid && (aw_cnt == aw_lat);
        if (bus.awready) begin got_aw = 1'b1; wr_idx = bus.awaddr[11:2]; end
        aw_cnt = bus.awvalid ? aw_cnt + 1 : 0;
        bus.wready = bus.wvalid && (w_cnt == w_lat);
        if (bus.wready) begin got_w = 1'b1; wr_dat = bus.wdata; end
        w_cnt = bus.wvalid ? w_cnt + 1 : 0;
        if (got_aw && got_w) begin
          resp_mem[wr_idx] = wr_dat;
          got_aw = 1'b0;
          got_w  = 1'b0;
        end
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
        if (r_wait > 0) begin
          r_wait--;
          if (r_wait == 0) begin
            bus.rvalid = 1'b1;
            bus.rdata  = resp_mem[ar_idx];
          end
        end
        bus.arready = bus.arvalid && bus.rready && !ar_never && (ar_cnt == ar_lat);
        if (bus.arready) begin
          ar_idx = bus.araddr[11:2];
          if (r_lat == 0) begin
            bus.rvalid = 1'b1;
            bus.rdata  = resp_mem[ar_idx];
          end else begin
            r_wait = r_lat;
          end
        end
        ar_cnt = bus.arvalid ? ar_cnt + 1 : 0;
      end
    end
  end

  // Monitor: count valid-high cycles per transaction and score each response.
  initial begin
    int  aw_hi = 0, w_hi = 0, ar_hi = 0, rise = 0;
    bit  prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge axis_clk);
      #2;
      if (!axis_rst_n) begin
        aw_hi = 0; w_hi = 0; ar_hi = 0; prev = 1'b0;
      end else begin
        if (bus.awvalid) aw_hi++;
        if (bus.wvalid)  w_hi++;
        if (bus.arvalid) ar_hi++;
        if (bus.rsp_valid && !prev) rise = cyc;
        prev = bus.rsp_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_rsp", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_err",   bus.rsp_err, e.err);
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_lat",   rise - e.acc, e.lat);
            chk("aw_hi",     aw_hi, e.aw_hi);
            chk("w_hi",      w_hi, e.w_hi);
            chk("ar_hi",     ar_hi, e.ar_hi);
          end
          aw_hi = 0; w_hi = 0; ar_hi = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[12] = 32'h4;
    axis_rst_n    = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 12'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge axis_clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'h0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 4'h0);
    chk("rst_addr_data", {bus.awaddr, bus.araddr, bus.wdata}, 56'h0);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    chk("cmd_ready_after_rst", bus.cmd_ready, 1'b1);

    // data_length <= 600 with an immediately ready responder
    do_cmd(1'b1, 12'h010, 32'h0000_0258, 1'b1);
    drain();
    chk("data_length", resp_mem[4], 32'd600);

    do_cmd(1'b1, 12'h024, 32'hFFFF_FFFE, 1'b1);
    drain();
    do_cmd(1'b0, 12'h024, 32'h0, 1'b1);
    drain();

    // skewed write: W three cycles behind AW, then the mirror case
    w_lat = 3;
    do_cmd(1'b1, 12'h028, 32'h1234_5678, 1'b1);
    drain();
    w_lat = 0; aw_lat = 2;
    do_cmd(1'b1, 12'h02C, 32'hA5A5_0F0F, 1'b1);
    drain();
    aw_lat = 0;

    // split read through RD_D
    r_lat = 3;
    do_cmd(1'b0, 12'h030, 32'h0, 1'b1);
    drain();
    r_lat = 0;

    // timeout, then normal traffic; then AR handshake on the last allowed cycle
    ar_never = 1'b1;
    do_cmd(1'b0, 12'h010, 32'h0, 1'b1);
    drain();
    ar_never = 1'b0;
    do_cmd(1'b0, 12'h010, 32'h0, 1'b1);
    drain();
    ar_lat = TMO - 1;
    do_cmd(1'b0, 12'h024, 32'h0, 1'b1);
    drain();
    ar_lat = 0;

    for (int i = 0; i < 6; i++) begin
      a = {4'h0, 6'($urandom_range(8, 63)), 2'b00};
      d = $urandom;
      do_cmd(1'b1, a, d, 1'b1);
      drain();
      do_cmd(1'b0, a, 32'h0, 1'b1);
      drain();
    end

    // response backpressure
    bus.rsp_ready = 1'b0;
    do_cmd(1'b0, 12'h024, 32'h0, 1'b1);
    for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge axis_clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'hFFFF_FFFE);
      chk("bp_cmd_ready", bus.cmd_ready, 1'b0);
      @(negedge axis_clk);
    end
    bus.rsp_ready = 1'b1;
    drain();

    // reset in the middle of a stalled write: nothing may come back
    aw_lat = 20; w_lat = 20;
    do_cmd(1'b1, 12'h040, 32'hDEAD_BEEF, 1'b0);
    repeat (2) @(negedge axis_clk);
    chk("pre_rst_valids", {bus.awvalid, bus.wvalid}, 2'b11);
    axis_rst_n = 1'b0;
    #1;
    chk("midrst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 4'h0);
    chk("midrst_outs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 35'h0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    aw_lat = 0; w_lat = 0;
    repeat (6) @(negedge axis_clk);
    chk("no_rsp_after_rst", bus.rsp_valid, 1'b0);
    chk("cmd_ready_after_midrst", bus.cmd_ready, 1'b1);
    chk("aborted_write", resp_mem[16], 32'h0);
    do_cmd(1'b0, 12'h010, 32'h0, 1'b1);
    drain();

    repeat (3) @(negedge axis_clk);
    chk("q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
